// File: rtl/riscv_mul_unit.sv
// Single-cycle-latency RISC-V M-extension multiplier (MUL/MULH/MULHU/MULHSU/MULW).
// The full product, high-half select and word flag are registered together; the output mux reads only registered state.
module riscv_mul_unit #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  input  logic                     mult_valid_i,
  input  logic [2:0]               operator_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  output logic [XLEN-1:0]          result_o,
  output logic                     mult_valid_o,
  output logic                     mult_ready_o,
  output logic [TRANS_ID_BITS-1:0] mult_trans_id_o
);

  localparam int unsigned PW = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHU  = 3'd2;
  localparam logic [2:0] OP_MULHSU = 3'd3;
  localparam logic [2:0] OP_MULW   = 3'd4;

  logic          sign_a;
  logic          sign_b;
  logic          sel_hi;
  logic          is_word;
  logic [PW-1:0] a_wide;
  logic [PW-1:0] b_wide;
  logic [PW-1:0] product;

  logic                     valid_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [PW-1:0]            prod_q;
  logic                     hi_q;
  logic                     word_q;
  logic [XLEN-1:0]          word_res;

  // Operator decode; reserved codes fall through to plain MUL.
  always_comb begin
    sign_a  = 1'b0;
    sign_b  = 1'b0;
    sel_hi  = 1'b0;
    is_word = 1'b0;
    case (operator_i)
      OP_MULH: begin
        sign_a = 1'b1;
        sign_b = 1'b1;
        sel_hi = 1'b1;
      end
      OP_MULHU:  sel_hi = 1'b1;
      OP_MULHSU: begin
        sign_a = 1'b1;
        sel_hi = 1'b1;
      end
      OP_MULW:   is_word = (XLEN == 64);
      OP_MUL:    sel_hi  = 1'b0;
      default:   sel_hi  = 1'b0;
    endcase
  end

  // Extending to 2*XLEN and keeping the low 2*XLEN bits gives the exact signed/unsigned product.
  always_comb begin
    a_wide  = {{XLEN{sign_a & operand_a_i[XLEN-1]}}, operand_a_i};
    b_wide  = {{XLEN{sign_b & operand_b_i[XLEN-1]}}, operand_b_i};
    product = a_wide * b_wide;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      prod_q  <= '0;
      hi_q    <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      valid_q <= mult_valid_i;
      // Payload only moves on an issue, so idle input activity cannot leak into results.
      if (mult_valid_i) begin
        id_q   <= trans_id_i;
        prod_q <= product;
        hi_q   <= sel_hi;
        word_q <= is_word;
      end
    end
  end

  generate
    if (XLEN == 64) begin : g_word64
      assign word_res = {{(XLEN-32){prod_q[31]}}, prod_q[31:0]};
    end else begin : g_word32
      assign word_res = prod_q[XLEN-1:0];
    end
  endgenerate

  always_comb begin
    result_o = prod_q[XLEN-1:0];
    if (hi_q) begin
      result_o = prod_q[PW-1:XLEN];
    end else if (word_q) begin
      result_o = word_res;
    end
  end

  assign mult_valid_o    = valid_q;
  assign mult_trans_id_o = id_q;
  assign mult_ready_o    = 1'b1;

endmodule

// File: tb/tb_riscv_mul_unit.sv
// Directed bench for riscv_mul_unit at XLEN=64: reset, each operator, pipelining and mid-flight reset.
module tb_riscv_mul_unit;

  localparam int unsigned XLEN = 64;
  localparam int unsigned TIDW = 3;

  logic            clk;
  logic            rst_n;
  logic [TIDW-1:0] trans_id;
  logic            valid_in;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [XLEN-1:0] result;
  logic            valid_out;
  logic            ready;
  logic [TIDW-1:0] id_out;

  int total;
  int bad;

  riscv_mul_unit #(.XLEN(XLEN), .TRANS_ID_BITS(TIDW)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .trans_id_i     (trans_id),
    .mult_valid_i   (valid_in),
    .operator_i     (op),
    .operand_a_i    (a),
    .operand_b_i    (b),
    .result_o       (result),
    .mult_valid_o   (valid_out),
    .mult_ready_o   (ready),
    .mult_trans_id_o(id_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [XLEN-1:0] x,
                       input logic [XLEN-1:0] y, input logic [TIDW-1:0] id);
    valid_in = v;
    op       = o;
    a        = x;
    b        = y;
    trans_id = id;
  endtask

  task automatic expect_out(input string tag, input logic [XLEN-1:0] res, input logic [TIDW-1:0] id);
    check({tag, "_valid"}, XLEN'(valid_out), XLEN'(1'b1));
    check({tag, "_result"}, result, res);
    check({tag, "_id"}, XLEN'(id_out), XLEN'(id));
  endtask

  task automatic single(input string tag, input logic [2:0] o, input logic [XLEN-1:0] x,
                        input logic [XLEN-1:0] y, input logic [TIDW-1:0] id, input logic [XLEN-1:0] res);
    drive(1'b1, o, x, y, id);
    @(negedge clk);
    expect_out(tag, res, id);
    drive(1'b0, 3'd0, '0, '0, '0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 3'd0, '0, '0, '0);

    // Reset state held over several cycles, with idle inputs wiggling.
    repeat (3) @(negedge clk);
    drive(1'b0, 3'd2, 64'hDEAD_BEEF, 64'h1234, 3'd5);
    @(negedge clk);
    check("rst_valid", XLEN'(valid_out), '0);
    check("rst_result", result, '0);
    check("rst_id", XLEN'(id_out), '0);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0);
    @(negedge clk);
    check("ready_after_rst", XLEN'(ready), XLEN'(1'b1));
    check("idle_valid", XLEN'(valid_out), '0);

    // MUL basic and single-cycle valid pulse.
    single("mul_10x10", 3'd0, 64'd10, 64'd10, 3'd1, 64'd100);
    @(negedge clk);
    check("mul_pulse_drop", XLEN'(valid_out), '0);

    single("mulh_m1xm1", 3'd1, '1, '1, 3'd2, 64'd0);
    single("mulhu_max", 3'd2, '1, '1, 3'd3, 64'hFFFF_FFFF_FFFF_FFFE);
    single("mulhsu_m1x2", 3'd3, '1, 64'd2, 3'd4, 64'hFFFF_FFFF_FFFF_FFFF);
    single("mulh_min_x2", 3'd1, 64'h8000_0000_0000_0000, 64'd2, 3'd5, 64'hFFFF_FFFF_FFFF_FFFF);
    single("mulhsu_m1xbig", 3'd3, '1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd6, 64'hFFFF_FFFF_FFFF_FFFF);
    single("mulw_sext", 3'd4, 64'h7FFF_FFFF, 64'd2, 3'd7, 64'hFFFF_FFFF_FFFF_FFFE);
    single("mulw_upper_ign", 3'd4, 64'h1_0000_0003, 64'd5, 3'd0, 64'd15);
    single("mul_full_low", 3'd0, 64'h1_0000_0003, 64'd5, 3'd1, 64'h5_0000_000F);
    single("reserved_op5", 3'd5, 64'd6, 64'd7, 3'd2, 64'd42);
    single("reserved_op7", 3'd7, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFD);

    // Idle input changes must not produce a valid.
    drive(1'b0, 3'd2, 64'd99, 64'd99, 3'd6);
    @(negedge clk);
    check("idle_change_valid", XLEN'(valid_out), '0);

    // Back-to-back issues.
    drive(1'b1, 3'd0, 64'd3, 64'd4, 3'd2);
    @(negedge clk);
    expect_out("pipe0", 64'd12, 3'd2);
    drive(1'b1, 3'd2, 64'h8000_0000_0000_0000, 64'd4, 3'd3);
    @(negedge clk);
    expect_out("pipe1", 64'd2, 3'd3);
    drive(1'b1, 3'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7, 3'd4);
    @(negedge clk);
    expect_out("pipe2", 64'hFFFF_FFFF_FFFF_FFF2, 3'd4);
    drive(1'b0, 3'd0, '0, '0, '0);
    @(negedge clk);
    check("pipe_end_valid", XLEN'(valid_out), '0);

    // Reset asserted between issue and capture edge drops the op.
    drive(1'b1, 3'd0, 64'd9, 64'd9, 3'd5);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", XLEN'(valid_out), '0);
    check("midrst_result", result, '0);
    check("midrst_id", XLEN'(id_out), '0);
    rst_n = 1'b1;
    drive(1'b0, 3'd0, '0, '0, '0);
    @(negedge clk);
    check("midrst_after_valid", XLEN'(valid_out), '0);

    // Reset while a valid is being presented clears it asynchronously.
    drive(1'b1, 3'd0, 64'd5, 64'd5, 3'd6);
    @(negedge clk);
    expect_out("pre_async", 64'd25, 3'd6);
    drive(1'b0, 3'd0, '0, '0, '0);
    rst_n = 1'b0;
    #1;
    check("async_valid", XLEN'(valid_out), '0);
    check("async_result", result, '0);
    check("async_id", XLEN'(id_out), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_async_ready", XLEN'(ready), XLEN'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_mul_unit.md
Name: riscv_mul_unit

Overview:
- Fully pipelined integer multiply functional unit for the RV64/RV32 execute stage.
- Implements the RISC-V M-extension multiply ops: MUL, MULH, MULHU, MULHSU, MULW.
- Fixed one-cycle latency; never stalls.
- Carries the scoreboard transaction ID alongside each result so writeback can retire it.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- TRANS_ID_BITS, 3, width of the scoreboard transaction ID.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- trans_id_i  in  TRANS_ID_BITS  ID of the issued instruction.
- mult_valid_i  in  1  issue strobe; operands and operator valid this cycle.
- operator_i  in  3  op select: 0=MUL, 1=MULH, 2=MULHU, 3=MULHSU, 4=MULW, 5-7 reserved.
- operand_a_i  in  XLEN  rs1 value.
- operand_b_i  in  XLEN  rs2 value.
- result_o  out  XLEN  product result.
- mult_valid_o  out  1  result_o and mult_trans_id_o valid this cycle.
- mult_ready_o  out  1  unit can accept an issue.
- mult_trans_id_o  out  TRANS_ID_BITS  ID belonging to result_o.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: mult_valid_o=0, mult_trans_id_o=0, result_o=0, all pipeline registers=0.
- mult_ready_o is constant 1 out of reset; the unit accepts a new op every cycle.
- Latency: an op sampled at rising edge N has mult_valid_o=1 with its result and ID throughout cycle N+1, i.e. until edge N+1.
- mult_valid_o is a registered copy of mult_valid_i. It is high exactly one cycle per issue.
- Back-to-back issues give back-to-back valids, in order, with no bubbles.
- When mult_valid_i=0 at an edge, mult_valid_o goes 0 next cycle. result_o and mult_trans_id_o may hold stale values; consumers qualify them with valid.
- Arithmetic: form a 2*XLEN-bit product of sign/zero-extended operands.
  - MUL: low XLEN bits of the product; signedness irrelevant.
  - MULH: a signed × b signed, high XLEN bits.
  - MULHU: a unsigned × b unsigned, high XLEN bits.
  - MULHSU: a signed × b unsigned, high XLEN bits.
  - MULW (XLEN=64 only): low 32 bits of a[31:0]×b[31:0], sign-extended from bit 31 to 64 bits. With XLEN=32, MULW behaves as MUL.
  - Reserved operator codes behave as MUL.
- Operator class and the half-select are registered together with the product, so the output mux uses values from the issuing cycle.
- No overflow or exception signalling; results wrap per the ISA.
- Reset asserted mid-operation clears mult_valid_o immediately (asynchronously). In-flight ops are dropped and never produce a valid.
- Changing inputs while mult_valid_i=0 has no effect on any future valid output.

Test Plan:
- Reset check: hold rst_ni=0 for several cycles -> mult_valid_o=0, result_o=0, mult_trans_id_o=0, mult_ready_o=1 after release.
- MUL basic: issue MUL a=10, b=10, ID=1 -> next cycle mult_valid_o=1, result_o=100, mult_trans_id_o=1. The cycle after, mult_valid_o=0.
- High-half variants, XLEN=64:
  - MULH a=-1, b=-1 -> result_o=0.
  - MULHU a=b=0xFFFF_FFFF_FFFF_FFFF -> result_o=0xFFFF_FFFF_FFFF_FFFE.
  - MULHSU a=-1, b=2 -> result_o=0xFFFF_FFFF_FFFF_FFFF.
- MULW sign extension: a=0x7FFF_FFFF, b=2 -> result_o=0xFFFF_FFFF_FFFF_FFFE. Also a=0x1_0000_0003, b=5 -> result_o=15, confirming upper bits are ignored.
- Pipelining: issue three consecutive ops (MUL 3×4 ID=2, MULHU 2^63×4 ID=3, MUL -2×7 ID=4) -> three consecutive valid cycles with results 12, 2, 0xFFFF_FFFF_FFFF_FFF2 and IDs 2, 3, 4.
- Reset mid-flight: issue MUL, assert rst_ni low before the next edge -> mult_valid_o never rises for that op; outputs return to reset values.
